// File: rtl/cp0_exc_seq.sv
// cp0_exc_seq: arbiter and sequencer for the single CP0 register-file write
// port. Serialises exception/interrupt entry (EPC, Cause, Status), ERET
// return (Status) and software MTC0 writes. It also drives pipeline flush and
// PC redirect for the multi-cycle core.
module cp0_exc_seq #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [4:0]  REG_STATUS = 5'd12,
   parameter logic [4:0]  REG_CAUSE  = 5'd13,
   parameter logic [4:0]  REG_EPC    = 5'd14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_req_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_bd_i,
   input  logic        eret_req_i,
   input  logic        boundary_i,
   input  logic        mtc0_req_i,
   input  logic [4:0]  mtc0_addr_i,
   input  logic [31:0] mtc0_data_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o,
   output logic        ack_o,
   output logic        mtc0_gnt_o,
   output logic        busy_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        int_pending_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_EPC    = 3'd1,
      S_W_CAUSE  = 3'd2,
      S_W_STATUS = 3'd3,
      S_W_ERET   = 3'd4,
      S_W_MTC0   = 3'd5,
      S_REDIR    = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  code_q;
   logic [31:0] pc_q;
   logic        bd_q;
   logic [31:0] tgt_q, tgt_d;
   logic [4:0]  maddr_q;
   logic [31:0] mdata_q;

   logic        we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        flush_q, flush_d;
   logic        busy_q, busy_d;
   logic        redir_q, redir_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic [31:0] wdata_s;

   logic        int_pending_s;
   logic        take_exc_s, take_int_s, take_eret_s, take_mtc0_s;

   // Cause bits that are overwritten by the entry sequence are never read.
   logic        unused_cause_s;
   assign unused_cause_s = ^{cause_i[31], cause_i[6:2]};

   // Interrupt pending: IE set, EXL clear, and some unmasked IP bit raised.
   assign int_pending_s = status_i[0] & ~status_i[1] &
                          (|(status_i[15:8] & cause_i[15:8]));

   // Fixed-priority arbitration, evaluated only while idle.
   always_comb begin
      take_exc_s  = 1'b0;
      take_int_s  = 1'b0;
      take_eret_s = 1'b0;
      take_mtc0_s = 1'b0;
      if (state_q == S_IDLE) begin
         if (exc_req_i) begin
            take_exc_s = 1'b1;
         end else if (int_pending_s && boundary_i) begin
            take_int_s = 1'b1;
         end else if (eret_req_i) begin
            take_eret_s = 1'b1;
         end else if (mtc0_req_i) begin
            take_mtc0_s = 1'b1;
         end else begin
            take_exc_s = 1'b0;
         end
      end else begin
         take_exc_s = 1'b0;
      end
   end

   // Next state, redirect target, and the output values of the next state.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      case (state_q)
         S_IDLE: begin
            if (take_exc_s || take_int_s) begin
               state_d = S_W_EPC;
            end else if (take_eret_s) begin
               state_d = S_W_ERET;
               tgt_d   = epc_i;
            end else if (take_mtc0_s) begin
               state_d = S_W_MTC0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_W_EPC:    state_d = S_W_CAUSE;
         S_W_CAUSE:  state_d = S_W_STATUS;
         S_W_STATUS: begin
            state_d = S_REDIR;
            tgt_d   = EXC_VECTOR;
         end
         S_W_ERET:   state_d = S_REDIR;
         S_W_MTC0:   state_d = S_IDLE;
         S_REDIR:    state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase

      we_d       = 1'b0;
      waddr_d    = 5'd0;
      flush_d    = 1'b0;
      busy_d     = (state_d != S_IDLE);
      redir_d    = 1'b0;
      redir_pc_d = 32'd0;
      case (state_d)
         S_W_EPC: begin
            we_d = 1'b1; waddr_d = REG_EPC; flush_d = 1'b1;
         end
         S_W_CAUSE: begin
            we_d = 1'b1; waddr_d = REG_CAUSE; flush_d = 1'b1;
         end
         S_W_STATUS, S_W_ERET: begin
            we_d = 1'b1; waddr_d = REG_STATUS; flush_d = 1'b1;
         end
         S_W_MTC0: begin
            // W_MTC0 is only entered from IDLE, so the live request is the target.
            we_d = 1'b1; waddr_d = mtc0_addr_i;
         end
         S_REDIR: begin
            flush_d = 1'b1; redir_d = 1'b1; redir_pc_d = tgt_d;
         end
         default: begin
            we_d = 1'b0;
         end
      endcase
   end

   // Write data follows the live Status/Cause values of the current write cycle.
   always_comb begin
      wdata_s = 32'd0;
      case (state_q)
         S_W_EPC:    wdata_s = bd_q ? (pc_q - 32'd4) : pc_q;
         S_W_CAUSE:  wdata_s = {bd_q, cause_i[30:7], code_q, cause_i[1:0]};
         S_W_STATUS: wdata_s = status_i | 32'h0000_0002;
         S_W_ERET:   wdata_s = status_i & ~32'h0000_0002;
         S_W_MTC0:   wdata_s = mdata_q;
         default:    wdata_s = 32'd0;
      endcase
   end

   // Sequencer state, request latches and registered output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         code_q     <= 5'd0;
         pc_q       <= 32'd0;
         bd_q       <= 1'b0;
         tgt_q      <= 32'd0;
         maddr_q    <= 5'd0;
         mdata_q    <= 32'd0;
         we_q       <= 1'b0;
         waddr_q    <= 5'd0;
         flush_q    <= 1'b0;
         busy_q     <= 1'b0;
         redir_q    <= 1'b0;
         redir_pc_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         flush_q    <= flush_d;
         busy_q     <= busy_d;
         redir_q    <= redir_d;
         redir_pc_q <= redir_pc_d;
         if (take_exc_s) begin
            code_q <= exc_code_i;
            pc_q   <= exc_pc_i;
            bd_q   <= exc_bd_i;
         end else if (take_int_s) begin
            code_q <= 5'd0;
            pc_q   <= exc_pc_i;
            bd_q   <= exc_bd_i;
         end else if (take_mtc0_s) begin
            maddr_q <= mtc0_addr_i;
            mdata_q <= mtc0_data_i;
         end else begin
            code_q <= code_q;
         end
      end
   end

   assign int_pending_o = int_pending_s;
   assign ack_o         = take_exc_s | take_int_s | take_eret_s;
   assign mtc0_gnt_o    = take_mtc0_s;
   assign cp0_we_o      = we_q;
   assign cp0_waddr_o   = we_q ? waddr_q : 5'd0;
   assign cp0_wdata_o   = we_q ? wdata_s : 32'd0;
   assign busy_o        = busy_q;
   assign flush_o       = flush_q;
   assign redirect_o    = redir_q;
   assign redirect_pc_o = redir_pc_q;

   // The latched MTC0 address is carried in waddr_q; keep it for debug visibility.
   logic unused_maddr_s;
   assign unused_maddr_s = ^maddr_q;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Testbench for cp0_exc_seq: directed cases plus randomized requests. A
// reference model schedules expected writes/redirects into queues and a
// separate monitor pops and compares them as the DUT presents them.
module tb_cp0_exc_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        exc_req_i, exc_bd_i, eret_req_i, boundary_i, mtc0_req_i;
   logic [4:0]  exc_code_i, mtc0_addr_i;
   logic [31:0] exc_pc_i, mtc0_data_i, status_i, cause_i, epc_i;
   logic        cp0_we_o, ack_o, mtc0_gnt_o, busy_o, flush_o, redirect_o, int_pending_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_wdata_o, redirect_pc_o;

   always #5 clk = ~clk;

   cp0_exc_seq dut (
      .clk(clk), .rst(rst),
      .exc_req_i(exc_req_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
      .eret_req_i(eret_req_i), .boundary_i(boundary_i),
      .mtc0_req_i(mtc0_req_i), .mtc0_addr_i(mtc0_addr_i), .mtc0_data_i(mtc0_data_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
      .ack_o(ack_o), .mtc0_gnt_o(mtc0_gnt_o), .busy_o(busy_o), .flush_o(flush_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .int_pending_o(int_pending_o)
   );

   typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wr_t;
   typedef struct { int cyc; logic [31:0] pc; } rd_t;
   wr_t wq[$];
   rd_t rq[$];
   bit  flush_exp [0:8191];
   bit  busy_exp  [0:8191];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;
   int  free_at = 0;
   bit  mon_en = 1'b0;
   bit  last_ack, last_gnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_wr(input int c, input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.cyc = c; w.addr = a; w.data = d;
      wq.push_back(w);
   endtask

   task automatic push_rd(input int c, input logic [31:0] pc);
      rd_t r;
      r.cyc = c; r.pc = pc;
      rq.push_back(r);
   endtask

   task automatic mark(input int a, input int b, input bit fl);
      for (int k = a; k <= b; k++) begin
         flush_exp[k] = fl;
         busy_exp[k]  = 1'b1;
      end
   endtask

   // Reference model: decides acceptance from the priority rules and schedules results.
   task automatic model_step();
      bit         ip, e_ack, e_gnt;
      int         c;
      logic [4:0] code;
      c     = cyc;
      e_ack = 1'b0;
      e_gnt = 1'b0;
      ip = status_i[0] && !status_i[1] && ((status_i[15:8] & cause_i[15:8]) != 8'd0);
      chk("int_pending", {31'd0, int_pending_o}, {31'd0, ip});
      if (c >= free_at) begin
         if (exc_req_i || (ip && boundary_i)) begin
            code  = exc_req_i ? exc_code_i : 5'd0;
            e_ack = 1'b1;
            push_wr(c + 1, 5'd14, exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i);
            push_wr(c + 2, 5'd13, (cause_i & 32'h7FFF_FF83) | {exc_bd_i, 31'd0} | {25'd0, code, 2'd0});
            push_wr(c + 3, 5'd12, status_i | 32'd2);
            push_rd(c + 4, 32'hBFC0_0380);
            mark(c + 1, c + 4, 1'b1);
            free_at = c + 5;
         end else if (eret_req_i) begin
            e_ack = 1'b1;
            push_wr(c + 1, 5'd12, status_i & ~32'd2);
            push_rd(c + 2, epc_i);
            mark(c + 1, c + 2, 1'b1);
            free_at = c + 3;
         end else if (mtc0_req_i) begin
            e_gnt = 1'b1;
            push_wr(c + 1, mtc0_addr_i, mtc0_data_i);
            mark(c + 1, c + 1, 1'b0);
            free_at = c + 2;
         end
      end
      chk("ack", {31'd0, ack_o}, {31'd0, e_ack});
      chk("mtc0_gnt", {31'd0, mtc0_gnt_o}, {31'd0, e_gnt});
      last_ack = e_ack;
      last_gnt = e_gnt;
   endtask

   // Called at a negedge after inputs are set; leaves time at the next negedge.
   task automatic settle();
      #1;
      model_step();
      @(negedge clk);
   endtask

   task automatic hold_until(input bit want_gnt);
      int n;
      n = 0;
      settle();
      while (!(want_gnt ? last_gnt : last_ack) && n < 20) begin
         settle();
         n++;
      end
      if (!(want_gnt ? last_gnt : last_ack)) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: no acceptance after %0d cycles", n);
      end
   endtask

   task automatic wait_idle();
      while (cyc < free_at) settle();
   endtask

   task automatic clear_reqs();
      exc_req_i = 1'b0; eret_req_i = 1'b0; mtc0_req_i = 1'b0; boundary_i = 1'b0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every cycle's outputs against the scheduled expectations.
   always @(posedge clk) begin
      wr_t w;
      rd_t r;
      #2;
      if (mon_en) begin
         chk("flush", {31'd0, flush_o}, {31'd0, flush_exp[cyc]});
         chk("busy", {31'd0, busy_o}, {31'd0, busy_exp[cyc]});
         while (wq.size() > 0 && wq[0].cyc < cyc) begin
            w = wq.pop_front();
            vectors++; miscompares++;
            $display("FAIL missing_write: addr %h data %h due cycle %0d", w.addr, w.data, w.cyc);
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            r = rq.pop_front();
            vectors++; miscompares++;
            $display("FAIL missing_redirect: pc %h due cycle %0d", r.pc, r.cyc);
         end
         if (cp0_we_o) begin
            if (wq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_write: addr %h data %h cycle %0d", cp0_waddr_o, cp0_wdata_o, cyc);
            end else begin
               w = wq.pop_front();
               chk("wr_cycle", cyc, w.cyc);
               chk("wr_addr", {27'd0, cp0_waddr_o}, {27'd0, w.addr});
               chk("wr_data", cp0_wdata_o, w.data);
            end
         end else begin
            chk("idle_waddr", {27'd0, cp0_waddr_o}, 32'd0);
            chk("idle_wdata", cp0_wdata_o, 32'd0);
         end
         if (redirect_o) begin
            if (rq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_redirect: pc %h cycle %0d", redirect_pc_o, cyc);
            end else begin
               r = rq.pop_front();
               chk("redir_cycle", cyc, r.cyc);
               chk("redir_pc", redirect_pc_o, r.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_reqs();
      exc_code_i = 5'd0; exc_pc_i = 32'd0; exc_bd_i = 1'b0;
      mtc0_addr_i = 5'd0; mtc0_data_i = 32'd0;
      status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_we", {31'd0, cp0_we_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_flush", {31'd0, flush_o}, 32'd0);
      chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
      chk("rst_redirect_pc", redirect_pc_o, 32'd0);
      chk("rst_ack", {31'd0, ack_o}, 32'd0);
      rst = 1'b0;

      // Reset asserted in the middle of W_CAUSE aborts the sequence
      @(negedge clk);
      exc_req_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h8000_0100;
      #1 chk("abort_ack", {31'd0, ack_o}, 32'd1);
      @(negedge clk);
      exc_req_i = 1'b0;
      @(posedge clk);
      #2;
      chk("abort_pre_we", {31'd0, cp0_we_o}, 32'd1);
      chk("abort_pre_addr", {27'd0, cp0_waddr_o}, 32'd13);
      #1 rst = 1'b1;
      #1;
      chk("abort_we", {31'd0, cp0_we_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_flush", {31'd0, flush_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_abort_we", {31'd0, cp0_we_o}, 32'd0);
         chk("post_abort_redirect", {31'd0, redirect_o}, 32'd0);
         chk("post_abort_busy", {31'd0, busy_o}, 32'd0);
      end

      mon_en = 1'b1;

      // Synchronous exception, no delay slot
      status_i = 32'h0000_0001; cause_i = 32'd0;
      exc_req_i = 1'b1; exc_code_i = 5'd8; exc_pc_i = 32'h8000_1000; exc_bd_i = 1'b0;
      hold_until(1'b0);
      exc_req_i = 1'b0;
      wait_idle();

      // Interrupt at a boundary, delay slot
      status_i = 32'h0000_0401; cause_i = 32'h0000_0400; boundary_i = 1'b1;
      exc_pc_i = 32'h8000_0010; exc_bd_i = 1'b1;
      hold_until(1'b0);
      boundary_i = 1'b0;
      wait_idle();

      // ERET
      status_i = 32'h0000_0003; cause_i = 32'd0; epc_i = 32'h8000_2000; eret_req_i = 1'b1;
      hold_until(1'b0);
      eret_req_i = 1'b0;
      wait_idle();

      // Exception and MTC0 together: exception first, MTC0 after REDIR
      status_i = 32'h0000_0001;
      exc_req_i = 1'b1; exc_code_i = 5'd1; exc_pc_i = 32'h8000_3000; exc_bd_i = 1'b0;
      mtc0_req_i = 1'b1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'd5;
      settle();
      exc_req_i = 1'b0;
      hold_until(1'b1);
      mtc0_req_i = 1'b0;
      wait_idle();

      // EXL set masks a raised interrupt
      status_i = 32'h0000_0403; cause_i = 32'h0000_0400; boundary_i = 1'b1;
      repeat (4) settle();
      boundary_i = 1'b0;

      // pc = 0 in a delay slot wraps EPC
      status_i = 32'd0; cause_i = 32'd0;
      exc_req_i = 1'b1; exc_code_i = 5'd10; exc_pc_i = 32'd0; exc_bd_i = 1'b1;
      hold_until(1'b0);
      exc_req_i = 1'b0;
      wait_idle();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if (cyc >= free_at) begin
            status_i = $urandom;
            cause_i  = $urandom;
            epc_i    = $urandom;
         end
         exc_req_i   = ($urandom_range(0, 9) < 2);
         exc_code_i  = 5'($urandom);
         exc_pc_i    = (i % 17 == 0) ? 32'd0 : $urandom;
         exc_bd_i    = 1'($urandom);
         eret_req_i  = ($urandom_range(0, 9) < 2);
         boundary_i  = 1'($urandom);
         mtc0_req_i  = ($urandom_range(0, 9) < 3);
         mtc0_addr_i = 5'($urandom);
         mtc0_data_i = $urandom;
         settle();
      end
      clear_reqs();
      wait_idle();
      repeat (3) settle();
      chk("write_queue_drained", wq.size(), 32'd0);
      chk("redirect_queue_drained", rq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
